// File: rtl/blackjack_msg_tx.sv
// blackjack_msg_tx: serialises DEAL/FINISHED card messages into gapped UART byte strobes (checksum byte when BLACKJACK_TX_CHECKSUM_EN is defined)
module blackjack_msg_tx #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_deal,
  input  logic       send_dealer_finished,
  input  logic [3:0] first_card,
  input  logic [3:0] second_card,
  input  logic [3:0] third_card,
  input  logic       tx_ready,
  output logic       tx_wr,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       msg_done
);
  typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, DONE} state_t;
`ifdef BLACKJACK_TX_CHECKSUM_EN
  localparam logic [1:0] CK = 2'd1;
`else
  localparam logic [1:0] CK = 2'd0;
`endif
  state_t     state;
  logic       pend_deal, pend_fin, msg_fin;
  logic [3:0] pd_c1, pf_c2, pf_c3, m_a, m_b, gap_cnt;
  logic [1:0] idx, n_bytes;
  logic [7:0] byte_q;
  logic       want_deal, want_fin, take_deal, take_fin, gap_last;
  function automatic logic [7:0] build(input logic fin, input logic [1:0] i, input logic [3:0] a, input logic [3:0] b);
    return fin ? (i == 2'd0 ? {4'hB, a} : i == 2'd1 ? {4'hC, b} : {4'hE, a ^ b})
               : (i == 2'd0 ? {4'hA, a} : {4'hE, a});
  endfunction
  // request arbitration: DEAL wins over FINISHED, new requests win over stale pending ones
  always_comb begin
    want_deal = send_deal | pend_deal;
    want_fin  = send_dealer_finished | pend_fin;
    take_deal = (state == IDLE) & want_deal;
    take_fin  = (state == IDLE) & !want_deal & want_fin;
    n_bytes   = (msg_fin ? 2'd2 : 2'd1) + CK;
    gap_last  = ({1'b0, gap_cnt} + 5'd1) >= 5'(GAP_CYCLES);
    busy      = (state != IDLE) | pend_deal | pend_fin;
  end
  // pending flags hold requests not taken this cycle; latest request of a type keeps its cards
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_deal <= 1'b0;
      pend_fin  <= 1'b0;
      pd_c1     <= 4'h0;
      pf_c2     <= 4'h0;
      pf_c3     <= 4'h0;
    end else begin
      pend_deal <= want_deal & !take_deal;
      pend_fin  <= want_fin & !take_fin;
      if (send_deal) pd_c1 <= first_card;
      if (send_dealer_finished) begin
        pf_c2 <= second_card;
        pf_c3 <= third_card;
      end
    end
  end
  // message FSM with registered strobe, data and done outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_wr    <= 1'b0;
      tx_data  <= 8'h00;
      msg_done <= 1'b0;
      msg_fin  <= 1'b0;
      m_a      <= 4'h0;
      m_b      <= 4'h0;
      idx      <= 2'd0;
      byte_q   <= 8'h00;
      gap_cnt  <= 4'h0;
    end else begin
      tx_wr    <= 1'b0;
      msg_done <= 1'b0;
      case (state)
        IDLE: begin
          if (take_deal) begin
            msg_fin <= 1'b0;
            m_a     <= send_deal ? first_card : pd_c1;
            m_b     <= 4'h0;
            state   <= LOAD;
          end else if (take_fin) begin
            msg_fin <= 1'b1;
            m_a     <= send_dealer_finished ? second_card : pf_c2;
            m_b     <= send_dealer_finished ? third_card : pf_c3;
            state   <= LOAD;
          end
        end
        LOAD: begin
          idx    <= 2'd0;
          byte_q <= build(msg_fin, 2'd0, m_a, m_b);
          state  <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            tx_wr   <= 1'b1;
            tx_data <= byte_q;
            idx     <= idx + 2'd1;
            gap_cnt <= 4'h0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_last) begin
            gap_cnt  <= 4'h0;
            byte_q   <= build(msg_fin, idx, m_a, m_b);
            msg_done <= idx == n_bytes;
            state    <= idx == n_bytes ? DONE : SEND;
          end else begin
            gap_cnt <= gap_cnt + 4'h1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blackjack_msg_tx.sv
// tb_blackjack_msg_tx: directed scoreboard bench for blackjack_msg_tx
module tb_blackjack_msg_tx;
  localparam int GAP = 2;
`ifdef BLACKJACK_TX_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic       clk, rst, send_deal, send_dealer_finished, tx_ready, tx_wr, busy, msg_done;
  logic [3:0] first_card, second_card, third_card;
  logic [7:0] tx_data;
  logic [7:0] exp_q[$];
  int         wr_cyc[$];
  int         n_cmp, n_err, cyc, done_cnt;

  blackjack_msg_tx #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .send_deal(send_deal), .send_dealer_finished(send_dealer_finished),
    .first_card(first_card), .second_card(second_card), .third_card(third_card),
    .tx_ready(tx_ready), .tx_wr(tx_wr), .tx_data(tx_data), .busy(busy), .msg_done(msg_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_deal(input logic [3:0] a);
    exp_q.push_back({4'hA, a});
    if (CK) exp_q.push_back({4'hE, a});
  endtask

  task automatic push_fin(input logic [3:0] b, input logic [3:0] c);
    exp_q.push_back({4'hB, b});
    exp_q.push_back({4'hC, c});
    if (CK) exp_q.push_back({4'hE, b ^ c});
  endtask

  task automatic wait_idle(input int max, input string tag);
    int k = 0;
    while (busy && k < max) begin
      tick();
      k++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  // scoreboard: every strobe pops one expected byte; spacing and ready are checked per strobe
  always @(negedge clk) begin
    if (msg_done) done_cnt++;
    if (tx_wr) begin
      chk("ready_at_strobe", {31'd0, tx_ready}, 32'd1);
      if (wr_cyc.size() > 0) chk("strobe_spacing", {31'd0, (cyc - wr_cyc[$]) >= GAP + 1}, 32'd1);
      wr_cyc.push_back(cyc);
      chk("strobe_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) chk("strobe_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    int d0, w0, k;
    bit drop;
    rst = 1'b1; send_deal = 1'b0; send_dealer_finished = 1'b0; tx_ready = 1'b1;
    first_card = 4'h0; second_card = 4'h0; third_card = 4'h0;
    n_cmp = 0; n_err = 0; cyc = 0; done_cnt = 0;
    #1;
    chk("rst_tx_wr", {31'd0, tx_wr}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_msg_done", {31'd0, msg_done}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    // single DEAL, card changed right after acceptance
    push_deal(4'h7);
    send_deal = 1'b1; first_card = 4'h7; d0 = done_cnt;
    tick();
    send_deal = 1'b0; first_card = 4'hF;
    chk("deal_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("deal_no_early_wr", {31'd0, tx_wr}, 32'd0);
    tick();
    chk("deal_latency_wr", {31'd0, tx_wr}, 32'd1);
    chk("deal_data", {24'd0, tx_data}, 32'hA7);
    wait_idle(30, "deal");
    chk("deal_done_count", done_cnt - d0, 32'd1);
    // FINISHED with gap timing
    push_fin(4'h3, 4'h9);
    send_dealer_finished = 1'b1; second_card = 4'h3; third_card = 4'h9;
    w0 = wr_cyc.size();
    tick();
    send_dealer_finished = 1'b0; second_card = 4'h0; third_card = 4'h0;
    wait_idle(40, "fin");
    chk("fin_strobe_count", wr_cyc.size() - w0, CK ? 32'd3 : 32'd2);
    if (wr_cyc.size() >= w0 + 2) chk("fin_spacing_1", wr_cyc[w0 + 1] - wr_cyc[w0], GAP + 1);
    if (CK && wr_cyc.size() >= w0 + 3) chk("fin_spacing_ck", wr_cyc[w0 + 2] - wr_cyc[w0 + 1], GAP + 1);
    // simultaneous requests: DEAL first, busy held across both messages
    push_deal(4'h5);
    push_fin(4'h2, 4'h4);
    send_deal = 1'b1; send_dealer_finished = 1'b1;
    first_card = 4'h5; second_card = 4'h2; third_card = 4'h4;
    d0 = done_cnt; drop = 1'b0; k = 0;
    tick();
    send_deal = 1'b0; send_dealer_finished = 1'b0;
    while (k < 80) begin
      tick();
      k++;
      if (done_cnt - d0 >= 2) break;
      if (!busy) drop = 1'b1;
    end
    chk("both_busy_continuous", {31'd0, drop}, 32'd0);
    chk("both_done_count", done_cnt - d0, 32'd2);
    wait_idle(10, "both");
    // pending while busy: FINISHED overwrite, DEAL served before FINISHED
    push_fin(4'h6, 4'h7);
    push_deal(4'h8);
    push_fin(4'h1, 4'h2);
    send_dealer_finished = 1'b1; second_card = 4'h6; third_card = 4'h7;
    tick();
    send_dealer_finished = 1'b0;
    tick();
    send_deal = 1'b1; first_card = 4'h8;
    tick();
    send_deal = 1'b0; send_dealer_finished = 1'b1; second_card = 4'h4; third_card = 4'h5;
    tick();
    second_card = 4'h1; third_card = 4'h2;
    tick();
    send_dealer_finished = 1'b0;
    wait_idle(150, "pend");
    chk("pend_queue_empty", exp_q.size(), 32'd0);
    // stall with tx_ready low during SEND
    tx_ready = 1'b0;
    push_deal(4'hC);
    send_deal = 1'b1; first_card = 4'hC;
    tick();
    send_deal = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_no_wr", {31'd0, tx_wr}, 32'd0);
      chk("stall_data_held", {24'd0, tx_data}, CK ? 32'hE3 : 32'hC2);
    end
    tx_ready = 1'b1;
    tick();
    chk("stall_release_wr", {31'd0, tx_wr}, 32'd1);
    chk("stall_release_data", {24'd0, tx_data}, 32'hAC);
    wait_idle(30, "stall");
    // reset between FINISHED bytes
    exp_q.push_back(8'hB3);
    send_dealer_finished = 1'b1; second_card = 4'h3; third_card = 4'h4;
    tick();
    send_dealer_finished = 1'b0;
    k = 0;
    while (!tx_wr && k < 10) begin
      tick();
      k++;
    end
    chk("abort_first_strobe", {31'd0, tx_wr}, 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("abort_tx_data", {24'd0, tx_data}, 32'd0);
    chk("abort_tx_wr", {31'd0, tx_wr}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_msg_done", {31'd0, msg_done}, 32'd0);
    tick(); tick();
    // request presented as reset releases is taken on the very next edge
    push_deal(4'h9);
    rst = 1'b0; send_deal = 1'b1; first_card = 4'h9;
    tick();
    send_deal = 1'b0;
    tick(); tick();
    chk("post_rst_wr", {31'd0, tx_wr}, 32'd1);
    chk("post_rst_data", {24'd0, tx_data}, 32'hA9);
    wait_idle(30, "post_rst");
    repeat (20) tick();
    chk("final_queue_empty", exp_q.size(), 32'd0);
    chk("final_busy", {31'd0, busy}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
